cikarma: RTL and testbench
==========================

# cikarma

- Bit-serial 32-bit fixed-point subtractor: computes `sayi1 - sayi2` on Q16.16 operands, one bit per clock, LSB first.
- Sits beside the bit-serial adder in the calculator datapath and presents the same 64-bit result layout, so the result mux and display logic treat both blocks identically.
- Adds an explicit start strobe and reset so the controller decides exactly when an operation begins.

## Interface

Parameters:
- None. Widths are fixed by the package constants (32-bit operands, 64-bit result, 16 fraction bits).

Ports:
- `clk`  input  1  Single clock. All state changes on the rising edge.
- `rst_n`  input  1  Reset, synchronous, active-low.
- `basla`  input  1  Start strobe. Sampled only while `hazir`=1.
- `sayi1`  input  32  Minuend, Q16.16. Captured on the accepting edge.
- `sayi2`  input  32  Subtrahend, Q16.16. Captured on the accepting edge.
- `sonuc`  output  64  Result: `{15'b0, odunc, fark[31:0], 16'b0}`.
- `hazir`  output  1  Block idle; it will accept `basla`.
- `gecerli`  output  1  `sonuc` and `tasma` hold a completed result.
- `tasma`  output  1  Signed (two's-complement) overflow of the subtraction.

## Operation

States:
- **BOS** (idle). `hazir`=1.
  - `basla`=1 → capture `sayi1` and `sayi2`, clear bit counter, set borrow register to 0, clear `gecerli`, go to **HESAP**.
- **HESAP** (compute). Bit `i` = counter value, 0..31.
  - Full-subtractor step: `d = a ^ b ^ br`; `br' = (~a & b) | (~(a ^ b) & br)`.
  - Write `fark[i] = d`, update borrow, increment counter.
  - After bit 31 → go to **BITTI**.
- **BITTI** (done). Single cycle.
  - `odunc` = final borrow. This is 1 exactly when `sayi1 < sayi2` as unsigned values.
  - `tasma = (sayi1[31] ^ sayi2[31]) & (sayi1[31] ^ fark[31])`.
  - Set `gecerli`=1, set `hazir`=1, return to **BOS**.

Behaviour rules:
- `fark = (sayi1 - sayi2) mod 2^32`.
- `sonuc` and `tasma` hold their last values until the next result completes.
- `basla` while busy is ignored; it is not queued.
- Input changes after the accepting edge have no effect on the running operation.
- `basla` held high → back-to-back operations.

## Timing

- Reset (`rst_n`=0 at an edge, from any state, including mid-HESAP):
  - state = BOS, `hazir`=1, `gecerli`=0, `sonuc`=0, `tasma`=0, counter=0, borrow=0.
  - Takes priority over `basla` on the same edge.
- Accept edge E (BOS, `basla`=1): after E, `hazir`=0 and `gecerli`=0.
- Edges E+1 … E+32 process bits 0…31.
- Edge E+33: BITTI commits the result.
  - After E+33: `hazir`=1, `gecerli`=1, `sonuc`/`tasma` valid.
- Busy window: `hazir` is low for exactly 33 cycles.
- Earliest next accept edge: E+34.
- `gecerli` stays high until the next accept edge or reset.

## Structure

Shared package `hesap_pkg`, reused by the adder and the other datapath blocks:
- `VERI_GENISLIGI`=32
- `SONUC_GENISLIGI`=64
- `KESIR_BIT`=16
- State encodings BOS/HESAP/BITTI
- Result-packing macro/function

Sub-module `tam_cikarici` (purely combinational):
- Inputs: `a`, `b`, `bin`.
- Outputs: `d`, `bout`.
- Instantiated once; the top block holds the FSM, 5-bit counter, operand and result shift/index registers, and flag logic.

## Test plan

1. 5.0 − 3.0: `sayi1`=0x00050000, `sayi2`=0x00030000, pulse `basla`.
   - `hazir` low for 33 cycles.
   - Then `sonuc`=0x0000_0002_0000_0000, `tasma`=0, `gecerli`=1.
2. 1.0 − 2.0: `sayi1`=0x00010000, `sayi2`=0x00020000.
   - `sonuc`=0x0001_FFFF_0000_0000 (odunc=1, fark=0xFFFF0000), `tasma`=0.
3. Signed overflow: `sayi1`=0x80000000, `sayi2`=0x00000001.
   - `sonuc`=0x0000_7FFF_FFFF_0000, `tasma`=1.
4. Equal operands: both 0x12345678.
   - `sonuc`=0, `tasma`=0, `gecerli`=1.
   - Operands changed and `basla` re-pulsed during HESAP: result unaffected and no second operation starts.
5. Reset mid-operation: drive `rst_n`=0 at the 10th HESAP cycle.
   - Next edge: `hazir`=1, `gecerli`=0, `sonuc`=0.
   - A new `basla` afterwards completes correctly, e.g. 0x00050000 − 0x00030000.
6. `basla` held high across two operations (7.5−2.25, then 0−0.5).
   - Second accept occurs at E+34.
   - Results: `sonuc`=0x0000_0005_4000_0000, then `sonuc`=0x0001_FFFF_8000_0000.
   - `gecerli` drops for the second computation.

Source files
------------

// File: rtl/hesap_pkg.sv
// hesap_pkg
// Shared constants and helpers for the bit-serial calculator datapath.
// The adder, subtractor and result mux all import this package so that
// operand widths, the result layout and FSM encodings stay in one place.
//   VERI_GENISLIGI  : operand width (Q16.16)
//   SONUC_GENISLIGI : packed result width
//   KESIR_BIT       : fraction bits, also the zero padding below the result
//   BOS/HESAP/BITTI : idle / compute / done state encodings
//   sonuc_paketle   : builds {zeros, carry/borrow, value, fraction zeros}
package hesap_pkg;

   localparam int VERI_GENISLIGI  = 32;
   localparam int SONUC_GENISLIGI = 64;
   localparam int KESIR_BIT       = 16;

   localparam logic [1:0] BOS   = 2'd0;
   localparam logic [1:0] HESAP = 2'd1;
   localparam logic [1:0] BITTI = 2'd2;

   // The flag bit sits directly above the value so the display logic can
   // treat an adder carry and a subtractor borrow the same way.
   function automatic logic [SONUC_GENISLIGI-1:0] sonuc_paketle(
      input logic                      bayrak,
      input logic [VERI_GENISLIGI-1:0] deger
   );
      return {{(SONUC_GENISLIGI-VERI_GENISLIGI-KESIR_BIT-1){1'b0}},
              bayrak, deger, {KESIR_BIT{1'b0}}};
   endfunction

endpackage

// File: rtl/tam_cikarici.sv
// tam_cikarici
// One-bit full subtractor, purely combinational.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the lower bit
//   d    : difference bit
//   bout : borrow out to the next bit
module tam_cikarici (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/cikarma.sv
// cikarma
// Bit-serial Q16.16 subtractor computing sayi1 - sayi2, one bit per clock,
// LSB first. Result layout matches the bit-serial adder.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   basla   : start strobe, only honoured while hazir=1
//   sayi1   : minuend, captured on the accepting edge
//   sayi2   : subtrahend, captured on the accepting edge
//   sonuc   : {15'b0, odunc, fark[31:0], 16'b0}, held until the next result
//   hazir   : idle, will accept basla
//   gecerli : sonuc/tasma hold a completed result
//   tasma   : two's-complement overflow of the subtraction
module cikarma
   import hesap_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       basla,
   input  logic [VERI_GENISLIGI-1:0]  sayi1,
   input  logic [VERI_GENISLIGI-1:0]  sayi2,
   output logic [SONUC_GENISLIGI-1:0] sonuc,
   output logic                       hazir,
   output logic                       gecerli,
   output logic                       tasma
);

   logic [1:0]                durum;
   logic [4:0]                sayac;
   logic [VERI_GENISLIGI-1:0] a_reg;
   logic [VERI_GENISLIGI-1:0] b_reg;
   logic [VERI_GENISLIGI-1:0] fark_reg;
   logic                      odunc_reg;
   logic                      d_bit;
   logic                      bout_bit;

   // Operands stay parallel and are indexed by the counter, so their MSBs
   // are still available for the overflow check once the loop is done.
   tam_cikarici u_tam_cikarici (
      .a    (a_reg[sayac]),
      .b    (b_reg[sayac]),
      .bin  (odunc_reg),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign hazir = (durum == BOS);

   // Controller: capture operands, walk the 32 bits, then commit the
   // packed result and flags in a single done cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         durum     <= BOS;
         sayac     <= 5'd0;
         a_reg     <= '0;
         b_reg     <= '0;
         fark_reg  <= '0;
         odunc_reg <= 1'b0;
         sonuc     <= '0;
         tasma     <= 1'b0;
         gecerli   <= 1'b0;
      end else begin
         case (durum)
            BOS: begin
               if (basla) begin
                  a_reg     <= sayi1;
                  b_reg     <= sayi2;
                  sayac     <= 5'd0;
                  odunc_reg <= 1'b0;
                  gecerli   <= 1'b0;
                  durum     <= HESAP;
               end
            end
            HESAP: begin
               fark_reg[sayac] <= d_bit;
               odunc_reg       <= bout_bit;
               sayac           <= sayac + 5'd1;
               if (sayac == 5'd31) begin
                  durum <= BITTI;
               end
            end
            BITTI: begin
               sonuc   <= sonuc_paketle(odunc_reg, fark_reg);
               // Overflow only when operand signs differ and the result
               // sign disagrees with the minuend.
               tasma   <= (a_reg[VERI_GENISLIGI-1] ^ b_reg[VERI_GENISLIGI-1]) &
                          (a_reg[VERI_GENISLIGI-1] ^ fark_reg[VERI_GENISLIGI-1]);
               gecerli <= 1'b1;
               durum   <= BOS;
            end
            default: begin
               durum <= BOS;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cikarma.sv
// tb_cikarma
// Scoreboard bench for the bit-serial subtractor. Each accepted operation
// pushes a reference result computed with plain integer arithmetic; an
// independent monitor pops and compares whenever gecerli rises.
module tb_cikarma;

   typedef struct {
      logic [63:0] sonuc;
      logic        tasma;
   } beklenen_t;

   logic        clk;
   logic        rst_n;
   logic        basla;
   logic [31:0] sayi1;
   logic [31:0] sayi2;
   logic [63:0] sonuc;
   logic        hazir;
   logic        gecerli;
   logic        tasma;

   beklenen_t   expq[$];
   int          total;
   int          bad;
   logic        gecerli_prev;
   logic [63:0] last_sonuc;

   cikarma dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .basla   (basla),
      .sayi1   (sayi1),
      .sayi2   (sayi2),
      .sonuc   (sonuc),
      .hazir   (hazir),
      .gecerli (gecerli),
      .tasma   (tasma)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: true difference, unsigned borrow, and overflow as
   // "the wrapped 32-bit result differs from the exact signed difference".
   function automatic beklenen_t modelHesap(input logic [31:0] s1, input logic [31:0] s2);
      beklenen_t   r;
      longint      tam;
      logic [31:0] f;
      logic        odunc;
      tam     = longint'($signed(s1)) - longint'($signed(s2));
      f       = s1 - s2;
      odunc   = (s1 < s2);
      r.sonuc = (64'(odunc) << 48) | (64'(f) << 16);
      r.tasma = (tam != longint'($signed(f)));
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
      end
   endtask

   // Monitor: compare on every rising gecerli
   initial begin
      gecerli_prev = 1'b0;
      last_sonuc   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && gecerli && !gecerli_prev) begin
            if (expq.size() == 0) begin
               checkOutput("beklenmeyen_sonuc", 64'd1, 64'd0);
            end else begin
               beklenen_t e;
               e = expq.pop_front();
               checkOutput("sonuc", sonuc, e.sonuc);
               checkOutput("tasma", 64'(tasma), 64'(e.tasma));
               last_sonuc = e.sonuc;
            end
         end
         gecerli_prev = gecerli;
      end
   end

   // Called at a negedge; waits (bounded) for hazir, then drives one accept
   task automatic acceptOp(input logic [31:0] s1, input logic [31:0] s2);
      int n;
      n = 0;
      while (!hazir && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("hazir_bekleme", 64'(hazir), 64'd1);
      basla = 1'b1;
      sayi1 = s1;
      sayi2 = s2;
      @(posedge clk);
      expq.push_back(modelHesap(s1, s2));
      #1;
      checkOutput("kabul_hazir", 64'(hazir), 64'd0);
      checkOutput("kabul_gecerli", 64'(gecerli), 64'd0);
   endtask

   // Counts busy cycles after an accept; optionally keeps basla high or
   // disturbs inputs/basla mid-computation. Returns at the negedge hazir=1.
   task automatic countBusy(input logic keep_basla, input logic disturb);
      int busy;
      busy = 0;
      forever begin
         @(negedge clk);
         if (hazir) break;
         busy++;
         if (busy > 200) begin
            checkOutput("mesgul_zaman_asimi", 64'(busy), 64'd33);
            break;
         end
         basla = keep_basla || (disturb && busy == 5);
         if (disturb && busy == 5) begin
            sayi1 = $urandom;
            sayi2 = $urandom;
         end
         if (busy == 20) checkOutput("sonuc_tutma", sonuc, last_sonuc);
      end
      if (busy <= 200) checkOutput("mesgul_sure", 64'(busy), 64'd33);
   endtask

   task automatic applyStimulus(input logic [31:0] s1, input logic [31:0] s2, input logic disturb);
      @(negedge clk);
      acceptOp(s1, s2);
      countBusy(1'b0, disturb);
   endtask

   function automatic logic [31:0] randomOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      basla = 1'b0;
      sayi1 = '0;
      sayi2 = '0;

      // Reset state, with basla asserted to confirm reset wins
      basla = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_hazir", 64'(hazir), 64'd1);
      checkOutput("reset_gecerli", 64'(gecerli), 64'd0);
      checkOutput("reset_sonuc", sonuc, 64'd0);
      checkOutput("reset_tasma", 64'(tasma), 64'd0);
      @(negedge clk);
      basla = 1'b0;
      rst_n = 1'b1;

      // Directed cases
      applyStimulus(32'h0005_0000, 32'h0003_0000, 1'b0);
      checkOutput("t1_sabit", sonuc, 64'h0000_0002_0000_0000);
      applyStimulus(32'h0001_0000, 32'h0002_0000, 1'b0);
      checkOutput("t2_sabit", sonuc, 64'h0001_FFFF_0000_0000);
      applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0);
      checkOutput("t3_sabit", sonuc, 64'h0000_7FFF_FFFF_0000);
      checkOutput("t3_tasma", 64'(tasma), 64'd1);
      applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1);
      checkOutput("t4_sabit", sonuc, 64'd0);
      checkOutput("t4_gecerli", 64'(gecerli), 64'd1);

      // Reset in the middle of a computation
      @(negedge clk);
      acceptOp(32'h0003_0000, 32'h0009_0000);
      repeat (10) begin
         @(negedge clk);
         basla = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      void'(expq.pop_back());
      last_sonuc = '0;
      checkOutput("araReset_hazir", 64'(hazir), 64'd1);
      checkOutput("araReset_gecerli", 64'(gecerli), 64'd0);
      checkOutput("araReset_sonuc", sonuc, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h0005_0000, 32'h0003_0000, 1'b0);
      checkOutput("t5_sabit", sonuc, 64'h0000_0002_0000_0000);

      // basla held high: back-to-back with next accept at E+34
      @(negedge clk);
      acceptOp(32'h0007_8000, 32'h0002_4000);
      sayi1 = 32'h0000_0000;
      sayi2 = 32'h0000_8000;
      countBusy(1'b1, 1'b0);
      checkOutput("t6_ilk", sonuc, 64'h0000_0005_4000_0000);
      acceptOp(32'h0000_0000, 32'h0000_8000);
      countBusy(1'b0, 1'b0);
      checkOutput("t6_ikinci", sonuc, 64'h0001_FFFF_8000_0000);

      // Randomized operations, some with mid-run disturbance and idle gaps
      for (int i = 0; i < 20; i++) begin
         applyStimulus(randomOperand(), randomOperand(), logic'(i % 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checkOutput("kuyruk_bos", 64'(expq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
